// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decoder/EX hazard inputs and pipeline control outputs
//   master: drives ID/EX hazard info, observes enables/flushes/counters
//   slave : the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int REG_AW = 5);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              id_multicycle;
    logic              ex_valid;
    logic              ex_mem_to_reg;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              ex_busy;
    logic [15:0]       stall_cycles;
    logic [7:0]        flush_count;
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_multicycle,
               ex_valid, ex_mem_to_reg, ex_rd, ex_branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_busy,
               stall_cycles, flush_count
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_multicycle,
               ex_valid, ex_mem_to_reg, ex_rd, ex_branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_busy,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and multi-cycle EX hold control
//   clk, rst (async, active-high)
//   hz: ID/EX hazard inputs in; PC/IF-ID/ID-EX enables and flushes, ex_busy,
//       saturating stall_cycles (pc_en=0 cycles) and flush_count (branch flushes) out
module pipeline_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MULTI} state_t;
    state_t      state_q, state_d;
    logic [3:0]  mc_cnt_q, mc_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic [7:0]  flush_q, flush_d;
    logic        load_use;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_busy;
    assign load_use = hz.ex_valid & hz.ex_mem_to_reg & hz.id_valid &
                      (hz.ex_rd != {REG_AW{1'b0}}) &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_busy     = 1'b0;
        if (rst) begin
            state_d  = RUN;
            mc_cnt_d = 4'd0;
        end else if (state_q == MULTI) begin
            // EX occupant is neither a branch nor a load, so hazard inputs are ignored
            ex_busy  = 1'b1;
            mc_cnt_d = mc_cnt_q - 4'd1;
            state_d  = (mc_cnt_q == 4'd1) ? RUN : MULTI;
        end else if (hz.ex_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            // only an instruction that really advances into EX starts the hold
            if (hz.id_valid & hz.id_multicycle) begin
                state_d  = MULTI;
                mc_cnt_d = 4'(MC_LATENCY - 1);
            end
        end
        stall_d = (!pc_en && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        flush_d = (if_id_flush && flush_q != 8'hFF) ? flush_q + 8'd1 : flush_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= 4'd0;
            stall_q  <= 16'd0;
            flush_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end
    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_busy      = ex_busy;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam logic [5:0] NRM = 6'b110100;
    localparam logic [5:0] BRN = 6'b111110;
    localparam logic [5:0] LDU = 6'b000110;
    localparam logic [5:0] MUL = 6'b000001;
    localparam logic [5:0] OFF = 6'b000000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] stall_m = '0;
    logic [7:0]  flush_m = '0;
    logic [5:0]  sb_q[$];
    pipeline_hazard_ctrl_if #(.REG_AW(5)) hz ();
    pipeline_hazard_ctrl #(.REG_AW(5), .MC_LATENCY(4)) dut (.clk(clk), .rst(rst), .hz(hz.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic set_in(input logic idv, input logic [4:0] rs2, input logic u2, input logic mc,
                          input logic exv, input logic ld, input logic [4:0] rd, input logic br);
        hz.id_valid = idv; hz.id_rs1 = 5'd0; hz.id_rs2 = rs2; hz.id_uses_rs1 = 1'b0;
        hz.id_uses_rs2 = u2; hz.id_multicycle = mc; hz.ex_valid = exv;
        hz.ex_mem_to_reg = ld; hz.ex_rd = rd; hz.ex_branch_taken = br;
    endtask
    task automatic cyc(input string tag, input logic [5:0] exp);
        logic [5:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        e = sb_q.pop_front();
        if (rst) begin stall_m = '0; flush_m = '0; end
        chk({tag, "_out"}, {10'd0, hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                             hz.id_ex_flush, hz.ex_busy}, {10'd0, e});
        chk({tag, "_stall"}, hz.stall_cycles, stall_m);
        chk({tag, "_flush"}, {8'd0, hz.flush_count}, {8'd0, flush_m});
        if (!rst) begin
            if (!e[5] && stall_m != 16'hFFFF) stall_m++;
            if (e[3] && flush_m != 8'hFF) flush_m++;
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        cyc("rst_hold", OFF);
        rst = 1'b0;
        cyc("first_run", NRM);
        set_in(1, 5, 1, 0, 1, 1, 5, 0);
        cyc("load_use", LDU);
        set_in(1, 5, 1, 0, 0, 0, 0, 0);
        cyc("after_lu", NRM);
        set_in(1, 0, 1, 0, 1, 1, 0, 0);
        cyc("rd_zero", NRM);
        set_in(1, 5, 1, 0, 1, 1, 5, 1);
        cyc("br_prio", BRN);
        set_in(1, 0, 0, 1, 1, 1, 5, 1);
        cyc("mc_in_branch", BRN);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cyc("after_br", NRM);
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        cyc("mc_issue", NRM);
        for (int i = 0; i < 3; i++) cyc("mc_busy1", MUL);
        cyc("mc_b2b_run", NRM);
        cyc("mc_busy2a", MUL);
        set_in(1, 5, 1, 1, 1, 1, 5, 1);
        cyc("mc_ignore", MUL);
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        cyc("mc_ignore2", MUL);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cyc("mc_exit", NRM);
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        cyc("mc_issue3", NRM);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cyc("mc_busy3", MUL);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mid_rst", OFF);
        rst = 1'b0;
        cyc("post_rst", NRM);
        set_in(1, 5, 1, 0, 1, 1, 5, 0);
        repeat (70000) @(posedge clk);
        #1;
        stall_m = 16'hFFFF;
        cyc("stall_sat", LDU);
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        repeat (300) @(posedge clk);
        #1;
        flush_m = 8'hFF;
        cyc("flush_sat", BRN);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("final", NRM);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage core's front half. Decides each cycle whether PC, IF/ID and ID/EX advance, hold, or are flushed: one-cycle load-use stalls, branch-taken flushes, and holding EX for multi-cycle ALU operations. Also keeps saturating stall/flush performance counters. Sits beside the decoder and drives the enable/flush pins of the PC register, IF/ID and ID/EX pipeline registers.

## Interface
- REG_AW, 5, register-address width
- MC_LATENCY, 4, total EX cycles of a multi-cycle op; legal range 2..16
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source registers of ID instruction
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_multicycle  in  1  ID instruction needs MC_LATENCY EX cycles
- ex_valid  in  1  EX stage holds a real instruction
- ex_mem_to_reg  in  1  EX instruction is a load
- ex_rd  in  REG_AW  destination of EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to bubble
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX clear to bubble (wins over id_ex_en)
- ex_busy  out  1  multi-cycle op occupying EX
- stall_cycles  out  16  count of cycles with pc_en=0
- flush_count  out  8  count of branch flushes

## Operation
- States: RUN, MULTI. Down-counter mc_cnt (4 bits).
- Outputs are Mealy: combinational from state and current inputs.
- load_use = ex_valid & ex_mem_to_reg & id_valid & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, priority order:
  - ex_branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1. Stay RUN. flush_count++.
  - else load_use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 (bubble into EX). Stay RUN.
  - else: all enables 1, flushes 0. If id_valid & id_multicycle, go to MULTI with mc_cnt=MC_LATENCY-1.
- MULTI: pc_en=0, if_id_en=0, id_ex_en=0, flushes 0, ex_busy=1.
  - mc_cnt decrements each cycle. When mc_cnt==1, the next state is RUN.
  - ex_branch_taken and load_use are ignored in MULTI, because the EX occupant is not a branch or load.
- ex_busy=0 in RUN.
- stall_cycles increments on every cycle with pc_en=0 outside reset. It saturates at 0xFFFF.
- flush_count saturates at 0xFF.

## Timing
- Reset (async assert): state=RUN, mc_cnt=0, stall_cycles=0, flush_count=0.
- While rst=1: pc_en=if_id_en=id_ex_en=0, if_id_flush=id_ex_flush=0, ex_busy=0.
- The first cycle after rst deasserts is normal RUN.
- Load-use: exactly one stall cycle. On the following cycle the load has moved to MEM, so load_use is false.
- Branch: flush is applied in the same cycle as ex_branch_taken. The two wrong-path instructions become bubbles at the next edge.
- Multi-cycle op enters EX at edge E0. EX is held for edges E1..E(MC_LATENCY-1), giving ex_busy=1 for MC_LATENCY-1 cycles. The pipeline advances again at edge E(MC_LATENCY).
- Multi-cycle op in ID during a load_use or branch cycle does not enter MULTI. It is re-evaluated when it actually advances.
- Back-to-back multi-cycle ops: RUN lasts one cycle between MULTI periods.
- rst asserted mid-MULTI: immediately returns to RUN and mc_cnt=0, and counters clear.

## Test plan
- Reset: assert rst for 3 cycles mid-traffic, then release.
  - Required: all outputs 0 during reset, counters 0 after release, pc_en=1 on the first free cycle.
- Load-use: ex_valid=1, ex_mem_to_reg=1, ex_rd=5; id_valid=1, id_uses_rs2=1, id_rs2=5.
  - Required: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then stall_cycles=1.
  - Repeat with ex_rd=0: required no stall.
- Branch priority: ex_branch_taken=1 together with a load_use condition.
  - Required: if_id_flush=id_ex_flush=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- Multi-cycle, MC_LATENCY=4: id_multicycle=1 in RUN.
  - Required: next 3 cycles ex_busy=1 with all enables 0, then RUN with enables 1, stall_cycles=3.
  - Issue a second multi-cycle op immediately: required one RUN cycle, then 3 more busy cycles.
- Ignore in MULTI: pulse ex_branch_taken and load_use inputs during MULTI.
  - Required: no flush, flush_count unchanged, MULTI exits on schedule.
- Saturation: force 70000 load-use stall cycles.
  - Required: stall_cycles holds at 0xFFFF.
  - Force 300 branch flushes: required flush_count holds at 0xFF.
